// File: rtl/digit_serial_subtractor_if.sv
// Handshake and operand/result bundle for the digit-serial subtractor.
// The requester drives start and the operands; the subtractor answers with
// busy/done and the registered result.
interface digit_serial_subtractor_if #(
  parameter int N = 16
);

  logic         start;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         Bin;
  logic         busy;
  logic         done;
  logic [N-1:0] Diff;
  logic         Bout;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Bout
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Bout
  );

endinterface

// File: rtl/digit_serial_subtractor.sv
// Digit-serial unsigned subtractor: Diff = (A - B - Bin) mod 2^N.
// The operands are latched when a request is accepted. One GROUP_SIZE-bit
// slice is then processed per clock, least significant slice first, with
// the borrow rippling from one slice to the next through a register.
// After the last slice a one-cycle done pulse is issued. Diff and Bout then
// hold until the next request is accepted.
// N must be an integer multiple of GROUP_SIZE. GROUP_SIZE = N gives a
// single processing cycle.
module digit_serial_subtractor #(
  parameter int N          = 16,
  parameter int GROUP_SIZE = 4
) (
  input logic                     clk,
  input logic                     rst,
  digit_serial_subtractor_if.slave bus
);

  localparam int NG = N / GROUP_SIZE;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST_GROUP = CW'(NG - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          state;
  logic [N-1:0]    a_reg;
  logic [N-1:0]    b_reg;
  logic [N-1:0]    diff_reg;
  logic            borrow;
  logic            bout_reg;
  logic            busy_reg;
  logic            done_reg;
  logic [CW-1:0]   grp_cnt;

  int                    grp_base;
  logic [GROUP_SIZE-1:0] a_grp;
  logic [GROUP_SIZE-1:0] b_grp;
  logic [GROUP_SIZE-1:0] d_grp;
  logic [GROUP_SIZE:0]   grp_sum;
  logic                  next_borrow;

  // One slice of a - b - borrow, computed as a + ~b + ~borrow; the carry-out of that sum is the inverted borrow-out
  always_comb begin
    grp_base    = int'(grp_cnt) * GROUP_SIZE;
    a_grp       = a_reg[grp_base +: GROUP_SIZE];
    b_grp       = b_reg[grp_base +: GROUP_SIZE];
    grp_sum     = {1'b0, a_grp} + {1'b0, ~b_grp} + {{GROUP_SIZE{1'b0}}, ~borrow};
    d_grp       = grp_sum[GROUP_SIZE-1:0];
    next_borrow = ~grp_sum[GROUP_SIZE];
  end

  // Control FSM and datapath: accept in IDLE/DONE, walk the slices in RUN, pulse done once and hold the result
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      a_reg    <= '0;
      b_reg    <= '0;
      diff_reg <= '0;
      borrow   <= 1'b0;
      bout_reg <= 1'b0;
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
      grp_cnt  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done_reg <= 1'b0;
          if (bus.start) begin
            a_reg    <= bus.A;
            b_reg    <= bus.B;
            borrow   <= bus.Bin;
            grp_cnt  <= '0;
            busy_reg <= 1'b1;
            state    <= RUN;
          end else begin
            busy_reg <= 1'b0;
            state    <= IDLE;
          end
        end
        RUN: begin
          diff_reg[grp_base +: GROUP_SIZE] <= d_grp;
          borrow <= next_borrow;
          if (grp_cnt == LAST_GROUP) begin
            bout_reg <= next_borrow;
            busy_reg <= 1'b0;
            done_reg <= 1'b1;
            grp_cnt  <= '0;
            state    <= DONE;
          end else begin
            grp_cnt <= grp_cnt + 1'b1;
          end
        end
        default: begin
          busy_reg <= 1'b0;
          done_reg <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy = busy_reg;
  assign bus.done = done_reg;
  assign bus.Diff = diff_reg;
  assign bus.Bout = bout_reg;

endmodule

// File: tb/tb_digit_serial_subtractor.sv
// Self-checking bench for digit_serial_subtractor (N=16, GROUP_SIZE=4)
// plus a single-slice instance (N=8, GROUP_SIZE=8).
module tb_digit_serial_subtractor;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  digit_serial_subtractor_if #(.N(16)) bus ();
  digit_serial_subtractor_if #(.N(8))  bus1 ();

  digit_serial_subtractor #(.N(16), .GROUP_SIZE(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  digit_serial_subtractor #(.N(8), .GROUP_SIZE(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        bin;
    logic [15:0] diff;
    logic        bout;
  } vec_t;

  vec_t vecs[9];

  int assert_count = 0;
  int fail_count   = 0;

  logic [15:0] got_diff;
  logic        got_bout;
  int          busy_cycles;
  bit          got_done;
  int          done_count;
  int          done_at[$];
  logic [15:0] ra;
  logic [15:0] rb;
  logic        rbin;
  logic [16:0] golden;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assert_count++;
    if (actual !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Reference: the subtraction done as a single 17-bit arithmetic operation
  function automatic logic [16:0] refSub(input logic [15:0] a, input logic [15:0] b, input logic bin);
    refSub = {1'b0, a} - {1'b0, b} - {16'd0, bin};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request one subtraction, scramble the inputs after acceptance, wait (bounded) for done
  task automatic applyStimulus(input logic [15:0] a, input logic [15:0] b, input logic bin,
                               output logic [15:0] diff, output logic bout,
                               output int nbusy, output bit finished);
    bus.A     = a;
    bus.B     = b;
    bus.Bin   = bin;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    bus.A     = ~a;
    bus.B     = ~b;
    bus.Bin   = ~bin;
    nbusy     = 0;
    finished  = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (bus.done) begin
        finished = 1'b1;
        break;
      end
      if (bus.busy) nbusy++;
      tick();
    end
    diff = bus.Diff;
    bout = bus.Bout;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0] = '{16'h1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1};
    vecs[3] = '{16'h8000, 16'h7FFF, 1'b1, 16'h0000, 1'b0};
    vecs[4] = '{16'h5555, 16'h5555, 1'b0, 16'h0000, 1'b0};
    vecs[5] = '{16'h0000, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    vecs[6] = '{16'hABCD, 16'h1234, 1'b0, 16'h9999, 1'b0};
    vecs[7] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0};
    vecs[8] = '{16'h0010, 16'h000F, 1'b1, 16'h0000, 1'b0};

    // Reset with start asserted: reset must win
    rst        = 1'b1;
    bus.start  = 1'b1;
    bus.A      = 16'h0001;
    bus.B      = 16'h0000;
    bus.Bin    = 1'b0;
    bus1.start = 1'b0;
    bus1.A     = 8'h00;
    bus1.B     = 8'h00;
    bus1.Bin   = 1'b0;
    tick();
    tick();
    checkOutput("reset busy", bus.busy, 0);
    checkOutput("reset done", bus.done, 0);
    checkOutput("reset Diff", bus.Diff, 0);
    checkOutput("reset Bout", bus.Bout, 0);
    bus.start = 1'b0;
    rst       = 1'b0;
    tick();
    checkOutput("post-reset busy", bus.busy, 0);
    checkOutput("post-reset done", bus.done, 0);

    // Directed table
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].bin, got_diff, got_bout, busy_cycles, got_done);
      checkOutput($sformatf("vec%0d done", i), got_done, 1);
      checkOutput($sformatf("vec%0d busy cycles", i), busy_cycles, 4);
      checkOutput($sformatf("vec%0d busy in done cycle", i), bus.busy, 0);
      checkOutput($sformatf("vec%0d Diff", i), got_diff, vecs[i].diff);
      checkOutput($sformatf("vec%0d Bout", i), got_bout, vecs[i].bout);
    end

    // start and new operands while busy are ignored
    bus.A     = 16'h00FF;
    bus.B     = 16'h000F;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.A     = 16'h0000;
    bus.B     = 16'hFFFF;
    tick();
    tick();
    bus.start  = 1'b0;
    done_count = 0;
    got_diff   = 16'h0;
    got_bout   = 1'b1;
    for (int i = 0; i < 15; i++) begin
      if (bus.done) begin
        done_count++;
        got_diff = bus.Diff;
        got_bout = bus.Bout;
      end
      tick();
    end
    checkOutput("busy-start done count", done_count, 1);
    checkOutput("busy-start Diff", got_diff, 16'h00F0);
    checkOutput("busy-start Bout", got_bout, 0);
    checkOutput("busy-start hold Diff", bus.Diff, 16'h00F0);

    // start held high: back-to-back operations, done every 5 cycles
    bus.A     = 16'h0F0F;
    bus.B     = 16'h1010;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    done_at.delete();
    for (int i = 0; i < 30; i++) begin
      tick();
      if (bus.done) begin
        done_at.push_back(i);
        checkOutput($sformatf("b2b Diff at %0d", i), bus.Diff, 16'hFEFF);
        checkOutput($sformatf("b2b Bout at %0d", i), bus.Bout, 1);
        checkOutput($sformatf("b2b busy at %0d", i), bus.busy, 0);
      end
    end
    bus.start = 1'b0;
    checkOutput("b2b done pulses", done_at.size(), 6);
    if (done_at.size() > 0) checkOutput("b2b first done", done_at[0], 4);
    for (int i = 1; i < done_at.size(); i++)
      checkOutput($sformatf("b2b gap %0d", i), done_at[i] - done_at[i-1], 5);
    tick();
    tick();

    // Reset in the second RUN cycle aborts the operation
    bus.A     = 16'h1234;
    bus.B     = 16'h0234;
    bus.Bin   = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    checkOutput("abort busy before reset", bus.busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("abort busy", bus.busy, 0);
    checkOutput("abort done", bus.done, 0);
    checkOutput("abort Diff", bus.Diff, 0);
    checkOutput("abort Bout", bus.Bout, 0);
    done_count = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.done) done_count++;
      tick();
    end
    checkOutput("abort no done", done_count, 0);

    // Random operands against the arithmetic reference
    for (int i = 0; i < 100; i++) begin
      ra     = 16'($urandom);
      rb     = 16'($urandom);
      rbin   = 1'($urandom);
      golden = refSub(ra, rb, rbin);
      applyStimulus(ra, rb, rbin, got_diff, got_bout, busy_cycles, got_done);
      checkOutput($sformatf("rand%0d done", i), got_done, 1);
      checkOutput($sformatf("rand%0d {Bout,Diff} A=%h B=%h Bin=%0d", i, ra, rb, rbin),
                  {got_bout, got_diff}, golden);
    end
    tick();
    tick();

    // Single-slice instance: one RUN cycle then DONE
    bus1.A     = 8'h10;
    bus1.B     = 8'h20;
    bus1.Bin   = 1'b0;
    bus1.start = 1'b1;
    tick();
    bus1.start = 1'b0;
    bus1.A     = 8'hFF;
    checkOutput("ng1 busy", bus1.busy, 1);
    checkOutput("ng1 no early done", bus1.done, 0);
    tick();
    checkOutput("ng1 done", bus1.done, 1);
    checkOutput("ng1 busy in done", bus1.busy, 0);
    checkOutput("ng1 Diff", bus1.Diff, 8'hF0);
    checkOutput("ng1 Bout", bus1.Bout, 1);
    tick();
    checkOutput("ng1 done single pulse", bus1.done, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end

endmodule

// File: doc/digit_serial_subtractor.md
DIGIT_SERIAL_SUBTRACTOR -- requirements
Module: digit_serial_subtractor

Interface
REQ-001 Parameter N, default 16: operand width in bits.
REQ-002 Parameter GROUP_SIZE, default 4: bits processed per cycle; N SHALL be an integer multiple of GROUP_SIZE; NG = N/GROUP_SIZE.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  request; sampled only while busy=0.
REQ-006 A  input  N  minuend, unsigned.
REQ-007 B  input  N  subtrahend, unsigned.
REQ-008 Bin  input  1  borrow-in.
REQ-009 busy  output  1  high while a subtraction is in progress.
REQ-010 done  output  1  single-cycle completion pulse.
REQ-011 Diff  output  N  result, (A - B - Bin) mod 2^N.
REQ-012 Bout  output  1  borrow-out; 1 iff A < B + Bin (unsigned).

Function
REQ-013 The FSM SHALL have states IDLE, RUN, DONE.
REQ-014 IDLE/DONE with start=1 at an edge: capture A, B, Bin into internal registers, clear group counter, go to RUN.
REQ-015 Operands SHALL be captured only on acceptance; input changes while busy=1 SHALL NOT affect the result.
REQ-016 RUN: each cycle computes one GROUP_SIZE-bit slice, LSB group first, as a_grp + ~b_grp + ~borrow, writing the slice into the Diff register and updating the internal borrow.
REQ-017 Group counter SHALL count 0..NG-1; on the edge processing group NG-1, go to DONE.
REQ-018 DONE: done=1 for exactly one cycle, then IDLE unless start=1 in that cycle (REQ-014).
REQ-019 busy SHALL be 1 exactly in RUN; 0 in IDLE and DONE.
REQ-020 Latency: start accepted at edge k -> busy=1 during cycles k+1..k+NG, done=1 during cycle k+NG+1.
REQ-021 start while busy=1 SHALL be ignored, with no effect on result or timing.
REQ-022 Diff and Bout SHALL be fully valid while done=1 and SHALL hold until the next acceptance; during RUN Diff is partial and undefined to consumers.
REQ-023 Bout SHALL equal the final internal borrow after group NG-1.
REQ-024 Wrap-around: A=B+Bin yields Diff=0, Bout=0; A<B+Bin yields two's-complement wrapped Diff with Bout=1.
REQ-025 NG=1 (GROUP_SIZE=N) SHALL be supported: one RUN cycle, then DONE.

Reset
REQ-026 rst=1 at an edge SHALL force IDLE, busy=0, done=0, Diff=0, Bout=0, counter=0, internal borrow=0.
REQ-027 rst SHALL dominate start in the same cycle; the request is not accepted.
REQ-028 Reset during RUN or DONE SHALL abort the operation; no done pulse is produced for it.

Verification (N=16, GROUP_SIZE=4)
REQ-029 A=0x1234, B=0x0234, Bin=0, start one cycle -> busy high 4 cycles, done on 5th cycle after acceptance edge, Diff=0x1000, Bout=0.
REQ-030 A=0x0000, B=0x0001, Bin=0 -> Diff=0xFFFF, Bout=1; A=0xFFFF, B=0xFFFF, Bin=1 -> Diff=0xFFFF, Bout=1; A=0x8000, B=0x7FFF, Bin=1 -> Diff=0x0000, Bout=0.
REQ-031 Accept A=0x00FF, B=0x000F; during busy drive start=1 with A=0, B=0xFFFF -> single done, Diff=0x00F0, Bout=0; no second done.
REQ-032 start held high continuously -> back-to-back operations, done every 5 cycles, acceptance in each DONE cycle.
REQ-033 rst=1 in 2nd RUN cycle -> next cycle busy=0, done=0, Diff=0, Bout=0; no done follows.
REQ-034 100 random {A, B, Bin} -> {Bout, Diff} equals golden {1'b0,A} - B - Bin (17-bit, MSB as borrow); error count reported, zero required.
